// File: rtl/peripheral_bus_arbiter.sv
// Round-robin arbiter that shares the single-port peripheral register file between bus masters.
// Optional lock lets one master issue back-to-back transactions, bounded by MAX_LOCK_CYCLES.
module peripheral_bus_arbiter #(
  parameter int          NUM_REQ         = 2,
  parameter int          MAX_LOCK_CYCLES = 8,
  parameter logic [31:0] RW_FIRST        = 32'h20,
  parameter logic [31:0] RW_LAST         = 32'h25,
  parameter logic [31:0] RO_ADDR         = 32'h26
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0]           req_lock,
  input  logic [NUM_REQ-1:0]           req_mode,
  input  logic [NUM_REQ*32-1:0]        req_addr,
  input  logic [NUM_REQ*32-1:0]        req_wdata,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [31:0]                  rsp_rdata,
  output logic                         rsp_err,
  output logic [31:0]                  per_address,
  output logic                         per_mode,
  output logic [31:0]                  per_data_in,
  input  logic [31:0]                  per_data_out,
  output logic [$clog2(NUM_REQ)-1:0]   owner
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_LOCK_CYCLES + 1) + 1;
  localparam logic [CW-1:0] MAXC = CW'(MAX_LOCK_CYCLES);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IW-1:0]      rr_q, rr_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic               lock_q, lock_d;
  logic               wr_q, wr_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [31:0]        per_address_q, per_address_d;
  logic               per_mode_q, per_mode_d;
  logic [31:0]        per_data_q, per_data_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic [31:0] addr_a  [NUM_REQ];
  logic [31:0] wdata_a [NUM_REQ];
  logic        win_found;
  logic [IW-1:0] win_idx;
  logic        launch;
  logic [IW-1:0] sel;
  logic        sel_wr;
  logic        sel_ok;
  logic [31:0] sel_addr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req_addr[32*g +: 32];
    assign wdata_a[g] = req_wdata[32*g +: 32];
  end

  function automatic logic is_legal(input logic wr, input logic [31:0] a);
    if (wr) return (a >= RW_FIRST) && (a <= RW_LAST);
    return (a >= RW_FIRST) && (a <= RO_ADDR);
  endfunction

  // First valid master strictly after the round-robin pointer.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    owner_d       = owner_q;
    lock_d        = lock_q;
    wr_d          = wr_q;
    err_d         = err_q;
    cnt_d         = '0;
    per_address_d = '0;
    per_mode_d    = 1'b0;
    per_data_d    = '0;
    ready_d       = '0;
    rsp_valid_d   = '0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    launch        = 1'b0;
    sel           = '0;
    sel_wr        = 1'b0;
    sel_ok        = 1'b0;
    sel_addr      = '0;

    if (state_q != IDLE && cnt_q != '1) cnt_d = cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          launch = 1'b1;
          sel    = win_idx;
        end
      end
      ISSUE: begin
        rsp_valid_d[owner_q] = 1'b1;
        rsp_err_d            = err_q;
        rsp_rdata_d          = (err_q || wr_q) ? 32'h0 : per_data_out;
        if (lock_q && cnt_q < MAXC) begin
          state_d = LOCKED;
        end else begin
          state_d = IDLE;
          rr_d    = owner_q;
          lock_d  = 1'b0;
        end
      end
      LOCKED: begin
        if (cnt_q >= MAXC || (!req_valid[owner_q] && !req_lock[owner_q])) begin
          state_d = IDLE;
          rr_d    = owner_q;
          lock_d  = 1'b0;
        end else if (req_valid[owner_q]) begin
          launch = 1'b1;
          sel    = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Illegal accesses still take an ISSUE slot but never reach the register file.
    if (launch) begin
      sel_addr      = addr_a[sel];
      sel_wr        = req_mode[sel];
      sel_ok        = is_legal(sel_wr, sel_addr);
      state_d       = ISSUE;
      owner_d       = sel;
      lock_d        = req_lock[sel];
      wr_d          = sel_wr;
      err_d         = !sel_ok;
      per_address_d = sel_ok ? sel_addr : 32'h0;
      per_mode_d    = sel_ok && sel_wr;
      per_data_d    = (sel_ok && sel_wr) ? wdata_a[sel] : 32'h0;
      ready_d[sel]  = 1'b1;
      if (state_q == IDLE) cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_q          <= IW'(NUM_REQ - 1);
      owner_q       <= '0;
      lock_q        <= 1'b0;
      wr_q          <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      per_address_q <= '0;
      per_mode_q    <= 1'b0;
      per_data_q    <= '0;
      ready_q       <= '0;
      rsp_valid_q   <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      owner_q       <= owner_d;
      lock_q        <= lock_d;
      wr_q          <= wr_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      per_address_q <= per_address_d;
      per_mode_q    <= per_mode_d;
      per_data_q    <= per_data_d;
      ready_q       <= ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign per_address = per_address_q;
  assign per_mode    = per_mode_q;
  assign per_data_in = per_data_q;
  assign owner       = owner_q;

endmodule

// File: tb/tb_peripheral_bus_arbiter.sv
// Directed bench for peripheral_bus_arbiter with a small register-file model on the per_* side.
module tb_peripheral_bus_arbiter;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req_valid, req_lock, req_mode;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] per_address, per_data_in, per_data_out;
  logic        per_mode;
  logic [0:0]  owner;

  logic [31:0] mem [0:7];
  logic [31:0] status_val;
  logic        mem_clr;

  int n_checks = 0;
  int n_pass   = 0;

  peripheral_bus_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_lock    (req_lock),
    .req_mode    (req_mode),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .per_address (per_address),
    .per_mode    (per_mode),
    .per_data_in (per_data_in),
    .per_data_out(per_data_out),
    .owner       (owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file: writable 0x20-0x25, status at 0x26, combinational read.
  always @(posedge clock) begin
    if (mem_clr) begin
      for (int i = 0; i < 8; i++) mem[i] <= 32'h1000_0000 + i;
    end else if (per_mode) begin
      mem[per_address[2:0]] <= per_data_in;
    end
  end

  assign per_data_out = (per_address >= 32'h20 && per_address <= 32'h25) ? mem[per_address[2:0]] :
                        (per_address == 32'h26) ? status_val : 32'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int m, input bit lk, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    req_valid[m]        = 1'b1;
    req_lock[m]         = lk;
    req_mode[m]         = wr;
    req_addr[32*m +: 32]  = a;
    req_wdata[32*m +: 32] = d;
  endtask

  task automatic clr_all();
    req_valid = '0;
    req_lock  = '0;
    req_mode  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  logic [1:0] exp4 [8]  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] exp5 [10] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};

  initial begin
    reset_n    = 1'b0;
    mem_clr    = 1'b1;
    status_val = 32'h0;
    clr_all();

    // Reset with random request activity
    for (int i = 0; i < 5; i++) begin
      req_valid = 2'($urandom);
      req_lock  = 2'($urandom);
      req_mode  = 2'($urandom);
      req_addr  = {$urandom, $urandom};
      req_wdata = {$urandom, $urandom};
      tick();
    end
    mem_clr = 1'b0;
    check("rst_per_address", 64'(per_address), 64'h0);
    check("rst_ctl", 64'({req_ready, rsp_valid, rsp_err, per_mode, owner}), 64'h0);
    check("rst_data", {rsp_rdata, per_data_in}, 64'h0);

    clr_all();
    set_req(0, 1'b0, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h21, 32'h0);
    reset_n = 1'b1;
    tick();
    check("first_grant_ready", 64'(req_ready), 64'h1);
    check("first_grant_owner", 64'(owner), 64'h0);
    clr_all();
    tick();
    tick();

    // M0 legal write
    set_req(0, 1'b0, 1'b1, 32'h23, 32'h0000_A5A5);
    tick();
    check("wr_addr", 64'(per_address), 64'h23);
    check("wr_mode", 64'(per_mode), 64'h1);
    check("wr_data", 64'(per_data_in), 64'hA5A5);
    check("wr_ready", 64'(req_ready), 64'h1);
    clr_all();
    tick();
    check("wr_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b01, 1'b0}));
    check("wr_rdata", 64'(rsp_rdata), 64'h0);
    check("wr_bus_idle", 64'(per_mode), 64'h0);
    check("wr_commit", 64'(mem[3]), 64'hA5A5);
    tick();

    // M1 status read
    status_val = 32'h1234_5678;
    set_req(1, 1'b0, 1'b0, 32'h26, 32'h0);
    tick();
    check("rd_mode", 64'(per_mode), 64'h0);
    check("rd_addr", 64'(per_address), 64'h26);
    check("rd_ready", 64'(req_ready), 64'h2);
    check("rd_owner", 64'(owner), 64'h1);
    clr_all();
    tick();
    check("rd_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b10, 1'b0}));
    check("rd_rdata", 64'(rsp_rdata), 64'h1234_5678);
    tick();

    // Both masters continuously valid, no lock: alternate grants every 2 cycles
    set_req(0, 1'b0, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h21, 32'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr_ready_%0d", i), 64'(req_ready), 64'(exp4[i]));
      if (i == 1) check("rr_rdata_m0", 64'(rsp_rdata), 64'h1000_0000);
    end
    clr_all();
    tick();
    tick();

    // M0 locked writes while M1 waits; lock expires after MAX_LOCK_CYCLES
    set_req(1, 1'b0, 1'b0, 32'h20, 32'h0);
    set_req(0, 1'b1, 1'b1, 32'h21, 32'hCAFE_0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("lock_ready_%0d", i), 64'(req_ready), 64'(exp5[i]));
      if (i == 0) begin
        check("lock_addr0", 64'(per_address), 64'h21);
        set_req(0, 1'b1, 1'b1, 32'h22, 32'hCAFE_0002);
      end
      if (i == 2) check("lock_addr1", 64'(per_address), 64'h22);
    end
    check("lock_m1_owner", 64'(owner), 64'h1);
    check("lock_mem1", 64'(mem[1]), 64'hCAFE_0001);
    check("lock_mem2", 64'(mem[2]), 64'hCAFE_0002);
    clr_all();
    tick();
    tick();

    // Illegal write to the status address
    set_req(0, 1'b0, 1'b1, 32'h26, 32'h0000_FFFF);
    tick();
    check("ilw_bus", 64'({per_mode, per_address}), 64'h0);
    check("ilw_ready", 64'(req_ready), 64'h1);
    clr_all();
    tick();
    check("ilw_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b01, 1'b1}));
    check("ilw_rdata", 64'(rsp_rdata), 64'h0);
    tick();

    // Illegal read outside the map
    set_req(1, 1'b0, 1'b0, 32'h30, 32'h0);
    tick();
    check("ilr_bus", 64'({per_mode, per_address}), 64'h0);
    check("ilr_ready", 64'(req_ready), 64'h2);
    clr_all();
    tick();
    check("ilr_rsp", 64'({rsp_valid, rsp_err}), 64'({2'b10, 1'b1}));
    check("ilr_rdata", 64'(rsp_rdata), 64'h0);
    tick();

    // Reset asserted during a write ISSUE drops the write
    set_req(0, 1'b0, 1'b1, 32'h24, 32'h5555_AAAA);
    tick();
    check("rstwr_mode_pre", 64'(per_mode), 64'h1);
    reset_n = 1'b0;
    #1;
    check("rstwr_mode_async", 64'({per_mode, per_address}), 64'h0);
    tick();
    check("rstwr_mem", 64'(mem[4]), 64'h1000_0004);
    clr_all();
    reset_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
